// File: rtl/captura_clave.sv
// Gate keypad PIN capture: collects four BCD digits while a vehicle is present,
// reports a complete PIN on enter, and discards partial entries on error or timeout.
module captura_clave #(
  parameter int unsigned TIMEOUT_CICLOS = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sensor_llegada_vehiculo,
  input  logic        tecla_valida,
  input  logic [3:0]  tecla,
  output logic [15:0] clave_ingresada,
  output logic        clave_lista,
  output logic [2:0]  digitos_ingresados,
  output logic        error_entrada,
  output logic        error_timeout
);

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned CLAVE_W   = 16;
  localparam int unsigned DIG_W     = 3;
  localparam logic [CNT_W-1:0] CNT_FIN      = CNT_W'(TIMEOUT_CICLOS - 1);
  localparam logic [3:0]       TECLA_BORRAR = 4'hA;
  localparam logic [3:0]       TECLA_ENTER  = 4'hB;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    CAPTURA  = 2'd1,
    COMPLETA = 2'd2
  } estado_t;

  estado_t              state, state_n;
  logic [CLAVE_W-1:0]   clave_n;
  logic [DIG_W-1:0]     digitos_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 lista_n, eent_n, etmo_n;
  logic                 acepta, es_digito, es_borrar, es_enter;

  // Key decode; codes 0xC-0xF match nothing and so leave everything untouched
  always_comb begin
    acepta    = tecla_valida && sensor_llegada_vehiculo;
    es_digito = acepta && (tecla <= 4'd9);
    es_borrar = acepta && (tecla == TECLA_BORRAR);
    es_enter  = acepta && (tecla == TECLA_ENTER);
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    clave_n   = clave_ingresada;
    digitos_n = digitos_ingresados;
    cnt_n     = cnt;
    lista_n   = 1'b0;
    eent_n    = 1'b0;
    etmo_n    = 1'b0;

    if (state != ESPERA && !sensor_llegada_vehiculo) begin
      // Vehicle left mid-entry: silent abort, beats any key or timeout
      state_n   = ESPERA;
      clave_n   = '0;
      digitos_n = '0;
      cnt_n     = '0;
    end else begin
      case (state)
        ESPERA: begin
          cnt_n = '0;
          if (es_digito) begin
            clave_n   = {12'h000, tecla};
            digitos_n = DIG_W'(1);
            state_n   = CAPTURA;
          end else if (es_borrar) begin
            clave_n = '0;
          end
        end
        CAPTURA: begin
          cnt_n = cnt + CNT_W'(1);
          if (es_digito) begin
            clave_n   = {clave_ingresada[11:0], tecla};
            digitos_n = digitos_ingresados + DIG_W'(1);
            cnt_n     = '0;
            if (digitos_ingresados == DIG_W'(3)) state_n = COMPLETA;
          end else if (es_enter) begin
            eent_n    = 1'b1;
            clave_n   = '0;
            digitos_n = '0;
            cnt_n     = '0;
            state_n   = ESPERA;
          end else if (es_borrar) begin
            clave_n   = '0;
            digitos_n = '0;
            cnt_n     = '0;
            state_n   = ESPERA;
          end else if (cnt == CNT_FIN) begin
            etmo_n    = 1'b1;
            clave_n   = '0;
            digitos_n = '0;
            cnt_n     = '0;
            state_n   = ESPERA;
          end
        end
        COMPLETA: begin
          cnt_n = cnt + CNT_W'(1);
          if (es_digito) begin
            // Extra digits are dropped but still count as user activity
            cnt_n = '0;
          end else if (es_enter) begin
            lista_n   = 1'b1;
            digitos_n = '0;
            cnt_n     = '0;
            state_n   = ESPERA;
          end else if (es_borrar) begin
            clave_n   = '0;
            digitos_n = '0;
            cnt_n     = '0;
            state_n   = ESPERA;
          end else if (cnt == CNT_FIN) begin
            etmo_n    = 1'b1;
            clave_n   = '0;
            digitos_n = '0;
            cnt_n     = '0;
            state_n   = ESPERA;
          end
        end
        default: begin
          state_n   = ESPERA;
          clave_n   = '0;
          digitos_n = '0;
          cnt_n     = '0;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= ESPERA;
      clave_ingresada    <= '0;
      digitos_ingresados <= '0;
      cnt                <= '0;
      clave_lista        <= 1'b0;
      error_entrada      <= 1'b0;
      error_timeout      <= 1'b0;
    end else begin
      state              <= state_n;
      clave_ingresada    <= clave_n;
      digitos_ingresados <= digitos_n;
      cnt                <= cnt_n;
      clave_lista        <= lista_n;
      error_entrada      <= eent_n;
      error_timeout      <= etmo_n;
    end
  end

endmodule

// File: tb/tb_captura_clave.sv
// Scoreboard bench for captura_clave: stimulus queues hand-computed output
// snapshots per cycle; a negedge monitor pops and compares them.
module tb_captura_clave;

  localparam int unsigned TMO = 8;

  logic        clock, reset, sensor, tv;
  logic [3:0]  tecla;
  logic [15:0] clave_ingresada;
  logic        clave_lista, error_entrada, error_timeout;
  logic [2:0]  digitos_ingresados;

  typedef struct packed {
    logic [15:0] clave;
    logic [2:0]  dig;
    logic        lista;
    logic        eent;
    logic        etmo;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  obs_t act;

  captura_clave #(.TIMEOUT_CICLOS(TMO)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .sensor_llegada_vehiculo (sensor),
    .tecla_valida            (tv),
    .tecla                   (tecla),
    .clave_ingresada         (clave_ingresada),
    .clave_lista             (clave_lista),
    .digitos_ingresados      (digitos_ingresados),
    .error_entrada           (error_entrada),
    .error_timeout           (error_timeout)
  );

  assign act = {clave_ingresada, digitos_ingresados, clave_lista, error_entrada, error_timeout};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare queued snapshot for this cycle, else require no pulses
  always @(negedge clock) begin
    exp_t e;
    if (cyc > 0) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        n_chk++;
        $display("FAIL missed_check cycle=%0d expected clave=%h dig=%0d", e.cyc, e.o.clave, e.o.dig);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (act === e.o) n_pass++;
        else $display("FAIL outputs cycle=%0d got clave=%h dig=%0d lista/eent/etmo=%b%b%b required clave=%h dig=%0d lista/eent/etmo=%b%b%b",
                      cyc, act.clave, act.dig, act.lista, act.eent, act.etmo,
                      e.o.clave, e.o.dig, e.o.lista, e.o.eent, e.o.etmo);
      end else begin
        n_chk++;
        if ({clave_lista, error_entrada, error_timeout} === 3'b000) n_pass++;
        else $display("FAIL spurious_pulse cycle=%0d got lista/eent/etmo=%b%b%b required 000",
                      cyc, clave_lista, error_entrada, error_timeout);
      end
    end
  end

  task automatic drive(input logic r, input logic s, input logic v, input logic [3:0] k);
    @(negedge clock);
    reset  = r;
    sensor = s;
    tv     = v;
    tecla  = k;
  endtask

  task automatic expect_out(input logic [15:0] c, input logic [2:0] d,
                            input logic l, input logic ee, input logic et);
    exp_t e;
    e.cyc = cyc + 1;
    e.o   = {c, d, l, ee, et};
    sb.push_back(e);
  endtask

  task automatic key(input logic [3:0] k, input logic [15:0] c, input logic [2:0] d,
                     input logic l, input logic ee, input logic et);
    drive(1'b0, 1'b1, 1'b1, k);
    expect_out(c, d, l, ee, et);
  endtask

  task automatic idle(input logic [15:0] c, input logic [2:0] d,
                      input logic l, input logic ee, input logic et);
    drive(1'b0, 1'b1, 1'b0, 4'h0);
    expect_out(c, d, l, ee, et);
  endtask

  initial begin
    reset  = 1'b1;
    sensor = 1'b0;
    tv     = 1'b0;
    tecla  = 4'h0;

    // Reset state, and reset beating a concurrent key
    drive(1'b1, 1'b0, 1'b0, 4'h0); expect_out(16'h0000, 3'd0, 0, 0, 0);
    drive(1'b1, 1'b1, 1'b1, 4'h5); expect_out(16'h0000, 3'd0, 0, 0, 0);

    // Full PIN 2468 then enter; value held, enter/borrar in ESPERA
    key(4'h2, 16'h0002, 3'd1, 0, 0, 0);
    key(4'h4, 16'h0024, 3'd2, 0, 0, 0);
    key(4'h6, 16'h0246, 3'd3, 0, 0, 0);
    key(4'h8, 16'h2468, 3'd4, 0, 0, 0);
    key(4'hB, 16'h2468, 3'd0, 1, 0, 0);
    idle(16'h2468, 3'd0, 0, 0, 0);
    key(4'hB, 16'h2468, 3'd0, 0, 0, 0);
    key(4'hA, 16'h0000, 3'd0, 0, 0, 0);

    // Short entry then enter
    key(4'h1, 16'h0001, 3'd1, 0, 0, 0);
    key(4'h2, 16'h0012, 3'd2, 0, 0, 0);
    key(4'hB, 16'h0000, 3'd0, 0, 1, 0);

    // Ignored code mid-entry, fifth digit dropped
    key(4'h1, 16'h0001, 3'd1, 0, 0, 0);
    key(4'h2, 16'h0012, 3'd2, 0, 0, 0);
    key(4'hE, 16'h0012, 3'd2, 0, 0, 0);
    key(4'h3, 16'h0123, 3'd3, 0, 0, 0);
    key(4'h4, 16'h1234, 3'd4, 0, 0, 0);
    key(4'h9, 16'h1234, 3'd4, 0, 0, 0);
    key(4'hB, 16'h1234, 3'd0, 1, 0, 0);

    // Borrar in CAPTURA
    key(4'h3, 16'h0003, 3'd1, 0, 0, 0);
    key(4'hA, 16'h0000, 3'd0, 0, 0, 0);

    // Timeout after TMO idle cycles
    key(4'h5, 16'h0005, 3'd1, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) idle(16'h0005, 3'd1, 0, 0, 0);
    idle(16'h0000, 3'd0, 0, 0, 1);
    idle(16'h0000, 3'd0, 0, 0, 0);

    // Key on the expiry cycle wins; ignored codes do not restart the counter
    key(4'h5, 16'h0005, 3'd1, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) idle(16'h0005, 3'd1, 0, 0, 0);
    key(4'h6, 16'h0056, 3'd2, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) key(4'hC, 16'h0056, 3'd2, 0, 0, 0);
    key(4'hC, 16'h0000, 3'd0, 0, 0, 1);

    // Sensor drop with simultaneous key; keys while sensor low
    key(4'h7, 16'h0007, 3'd1, 0, 0, 0);
    key(4'h7, 16'h0077, 3'd2, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 4'h7); expect_out(16'h0000, 3'd0, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 4'h3); expect_out(16'h0000, 3'd0, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 4'hB); expect_out(16'h0000, 3'd0, 0, 0, 0);
    key(4'h3, 16'h0003, 3'd1, 0, 0, 0);
    key(4'hA, 16'h0000, 3'd0, 0, 0, 0);

    // Sensor drop in COMPLETA beats enter
    key(4'h1, 16'h0001, 3'd1, 0, 0, 0);
    key(4'h2, 16'h0012, 3'd2, 0, 0, 0);
    key(4'h3, 16'h0123, 3'd3, 0, 0, 0);
    key(4'h4, 16'h1234, 3'd4, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 4'hB); expect_out(16'h0000, 3'd0, 0, 0, 0);

    // Reset mid-entry, then a fresh PIN
    key(4'h3, 16'h0003, 3'd1, 0, 0, 0);
    key(4'h3, 16'h0033, 3'd2, 0, 0, 0);
    key(4'h3, 16'h0333, 3'd3, 0, 0, 0);
    drive(1'b1, 1'b1, 1'b1, 4'h4); expect_out(16'h0000, 3'd0, 0, 0, 0);
    key(4'h4, 16'h0004, 3'd1, 0, 0, 0);
    key(4'h3, 16'h0043, 3'd2, 0, 0, 0);
    key(4'h2, 16'h0432, 3'd3, 0, 0, 0);
    key(4'h1, 16'h4321, 3'd4, 0, 0, 0);
    key(4'hB, 16'h4321, 3'd0, 1, 0, 0);
    idle(16'h4321, 3'd0, 0, 0, 0);

    repeat (3) drive(1'b0, 1'b1, 1'b0, 4'h0);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
